bus_arb_intercon: RTL and testbench
===================================

// Module: bus_arb_intercon
// PURPOSE
//  Multi-master, multi-slave bus interconnect with round-robin arbitration.
//  Lets the core's instruction and data masters (plus future DMA/debug masters)
//  share one bus to the text RAM, data RAM and UART slaves.
//  Adds address-decode error response and slave timeout, which the single-master intercon lacks.
//  One transaction in flight at a time.
// PARAMETERS
//  NUM_MASTERS  2             number of masters (1..8)
//  NUM_SLAVES   3             number of slaves (1..8)
//  ADDR_W       32            byte address width
//  DATA_W       32            data width, multiple of 8
//  SLAVE_BASE   '0            [NUM_SLAVES*ADDR_W] packed base byte address per slave
//  SLAVE_WORDS  '0            [NUM_SLAVES*ADDR_W] packed size in DATA_W words per slave
//  TIMEOUT      255           cycles in ACTIVE without s_ack before error (>=1)
// PORTS
//  clk       in   1                      clock, all logic on rising edge
//  rst_b     in   1                      asynchronous active-low reset
//  m_req     in   NUM_MASTERS            master request; held until m_ack
//  m_we      in   NUM_MASTERS            1=write, 0=read
//  m_addr    in   NUM_MASTERS*ADDR_W     byte address
//  m_wdata   in   NUM_MASTERS*DATA_W     write data
//  m_be      in   NUM_MASTERS*DATA_W/8   byte enables
//  m_ack     out  NUM_MASTERS            one-cycle completion pulse
//  m_err     out  NUM_MASTERS            qualifies m_ack: decode miss or timeout
//  m_rdata   out  DATA_W                 read data, valid with m_ack (shared)
//  s_req     out  NUM_SLAVES             one-hot slave request
//  s_we      out  1                      broadcast write enable
//  s_addr    out  ADDR_W                 broadcast address, offset from slave base
//  s_wdata   out  DATA_W                 broadcast write data
//  s_be      out  DATA_W/8               broadcast byte enables
//  s_ack     in   NUM_SLAVES             slave completion, one cycle
//  s_rdata   in   NUM_SLAVES*DATA_W      slave read data, valid with s_ack
// BEHAVIOUR
//  Reset: all outputs 0.
//    State IDLE.
//    RR pointer = NUM_MASTERS-1, so master 0 wins first.
//    Timeout counter 0.
//  FSM IDLE -> ACTIVE | ERR -> RESP -> IDLE.
//  IDLE:
//    If any m_req, grant the first requester at or after pointer+1 (mod NUM_MASTERS).
//    Register the grant, pointer := grant, latch we/addr/wdata/be.
//    Decode hit -> ACTIVE. Decode miss -> ERR.
//  Decode:
//    slave i hits if SLAVE_BASE[i] <= addr < SLAVE_BASE[i] + SLAVE_WORDS[i]*(DATA_W/8).
//    Lowest index wins on overlap.
//    s_addr = addr - SLAVE_BASE[i].
//  ACTIVE:
//    s_req[sel] = 1 and the broadcast signals are driven from registers.
//    Latency: m_req in cycle N (IDLE) gives s_req in cycle N+1.
//    s_ack[sel] seen: latch s_rdata[sel], drop s_req, go to RESP, err = 0.
//    Counter reaches TIMEOUT: drop s_req, go to RESP, err = 1.
//    s_ack from a non-selected slave is ignored.
//  ERR: one cycle, no s_req, err = 1, then RESP.
//  RESP:
//    m_ack[grant] = 1 and m_err[grant] = err for exactly one cycle; m_rdata = latched data.
//    m_rdata = 0 on writes and on errors.
//    Then IDLE; the earliest next grant is the cycle after RESP.
//  Masters must drop m_req on the edge after seeing m_ack; a req still high in IDLE is a new request.
//  A master dropping m_req mid-transaction does not abort it; RESP is still issued.
//  Simultaneous requests: strict round-robin; no master waits more than NUM_MASTERS-1 grants.
//  Reset asserted mid-transaction: immediate return to the reset state, s_req drops asynchronously.
//  Counter width = $clog2(TIMEOUT+1); it clears on entry to ACTIVE.
// STRUCTURE
//  bus package: intercon_state_e (IDLE/ACTIVE/ERR/RESP) and a decode function addr_hit(addr, base, words).
//  mmap_defines keeps the per-slave base/size constants that feed SLAVE_BASE/SLAVE_WORDS.
//  Sub-module rr_arbiter #(N): req[N], ptr, en -> one-hot gnt, gnt_idx (combinational).
//  The FSM, decode, latches and timeout stay in bus_arb_intercon.
// TESTING
//  1 Single read: M0 reads 0x0000_1004, slave0 base 0x1000, acks with 0xDEADBEEF 2 cycles later
//    -> s_addr=0x4, m_ack[0] with m_rdata=0xDEADBEEF, m_err=0.
//  2 Contention: M0 and M1 request together and continuously
//    -> grants M0,M1,M0,M1; each gets one m_ack per RESP.
//  3 Decode miss: M1 writes 0xFFFF_0000
//    -> no s_req ever; m_ack[1]=m_err[1]=1 three cycles after the request (IDLE,ERR,RESP).
//  4 Timeout: TIMEOUT=4, slave never acks
//    -> s_req high exactly 4 cycles, then m_ack+m_err; the next request is served normally.
//  5 Reset mid-ACTIVE: pull rst_b low
//    -> s_req and m_ack go 0 at once; after release M0 wins over a concurrent M1.
//  6 Write with byte enables: M0 writes 0x12345678, be=4'b0011
//    -> s_we=1, s_be=0011, s_wdata=0x12345678; m_rdata=0 on ack.

Source files
------------

// File: rtl/bus_arb_intercon_pkg.sv
// Shared types and helpers for the multi-master bus interconnect.
//   intercon_state_e : FSM states of bus_arb_intercon
//   addr_hit()       : address-window test used by the slave decoder
//   MMAP_*           : system memory map (text RAM, data RAM, UART) that feeds
//                      the SLAVE_BASE / SLAVE_WORDS parameters of the intercon
package bus_arb_intercon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2,
    ST_RESP   = 2'd3
  } intercon_state_e;

  // mmap_defines: base byte address and size in 32-bit words per slave
  localparam logic [31:0] MMAP_TEXT_BASE  = 32'h0000_1000;
  localparam logic [31:0] MMAP_TEXT_WORDS = 32'h0000_0400;
  localparam logic [31:0] MMAP_DATA_BASE  = 32'h0001_0000;
  localparam logic [31:0] MMAP_DATA_WORDS = 32'h0000_0400;
  localparam logic [31:0] MMAP_UART_BASE  = 32'h0002_0000;
  localparam logic [31:0] MMAP_UART_WORDS = 32'h0000_0004;

  // Slave 0 is in the low slice
  localparam logic [95:0] MMAP_SLAVE_BASE  = {MMAP_UART_BASE,  MMAP_DATA_BASE,  MMAP_TEXT_BASE};
  localparam logic [95:0] MMAP_SLAVE_WORDS = {MMAP_UART_WORDS, MMAP_DATA_WORDS, MMAP_TEXT_WORDS};

  // Evaluated in 64 bits so base + size cannot wrap for any ADDR_W <= 32.
  function automatic logic addr_hit(input logic [63:0] addr,
                                    input logic [63:0] base,
                                    input logic [63:0] words,
                                    input logic [63:0] bytes_per_word);
    return (addr >= base) && (addr < base + words * bytes_per_word);
  endfunction

endpackage

// File: rtl/bus_arb_intercon_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i     : request vector
//   ptr_i     : index of the last granted requester
//   en_i      : grant enable; no grant when low
//   gnt_o     : one-hot grant to the first requester at or after ptr_i+1 (mod N)
//   gnt_idx_o : binary index of the granted requester
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  always_comb begin
    logic [IW-1:0] idx;
    logic          found;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    // Walk from ptr+1 around the ring; the owner of ptr itself is checked last.
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(ptr_i) + k) % N);
      if (en_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arb_intercon.sv
// Multi-master / multi-slave bus interconnect, one transaction in flight.
//   clk_i, rst_ni          : clock (rising edge), async active-low reset
//   m_req_i/we/addr/wdata/be_i : per-master request, held until m_ack_o
//   m_ack_o, m_err_o       : one-cycle completion per master, err qualifies ack
//   m_rdata_o              : shared read data, valid with m_ack_o
//   s_req_o                : one-hot slave request
//   s_we/addr/wdata/be_o   : broadcast to slaves, addr is offset from slave base
//   s_ack_i, s_rdata_i     : per-slave completion and read data
//
// state  | meaning
// IDLE   | arbitrate, latch granted request, decode
// ACTIVE | s_req to selected slave, wait for its ack or timeout
// ERR    | decode miss, one cycle with no slave request
// RESP   | m_ack (and m_err) to the granted master for one cycle
module bus_arb_intercon
  import bus_arb_intercon_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE  = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_WORDS = '0,
  parameter int TIMEOUT     = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_MASTERS-1:0]        m_req_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_be_i,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [DATA_W-1:0]             m_rdata_o,
  output logic [NUM_SLAVES-1:0]         s_req_o,
  output logic                          s_we_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_wdata_o,
  output logic [DATA_W/8-1:0]           s_be_o,
  input  logic [NUM_SLAVES-1:0]         s_ack_i,
  input  logic [NUM_SLAVES*DATA_W-1:0]  s_rdata_i
);

  localparam int BE_W  = DATA_W / 8;
  localparam int MIW   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SIW   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  intercon_state_e        state_q;
  logic [MIW-1:0]         ptr_q, gnt_q;
  logic [SIW-1:0]         sel_q;
  logic                   we_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q, rdata_q;
  logic [BE_W-1:0]        be_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0]  s_req_q;
  logic [NUM_MASTERS-1:0] m_ack_q, m_err_q;

  logic [NUM_MASTERS-1:0] arb_gnt;
  logic [MIW-1:0]         arb_idx;
  logic [ADDR_W-1:0]      gaddr, off_d;
  logic [SIW-1:0]         sel_d;
  logic                   hit_d;
  logic [NUM_MASTERS-1:0] gnt_oh;
  logic                   sel_ack, timeout_hit;
  logic [DATA_W-1:0]      sel_rdata;

  rr_arbiter #(.N(NUM_MASTERS)) u_arb (
    .req_i     (m_req_i),
    .ptr_i     (ptr_q),
    .en_i      (state_q == ST_IDLE),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  assign gaddr = m_addr_i[int'(arb_idx)*ADDR_W +: ADDR_W];

  // Descending scan so the lowest matching slave index overrides the others.
  always_comb begin
    hit_d = 1'b0;
    sel_d = '0;
    off_d = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (addr_hit(64'(gaddr), 64'(SLAVE_BASE[i*ADDR_W +: ADDR_W]),
                   64'(SLAVE_WORDS[i*ADDR_W +: ADDR_W]), 64'(BE_W))) begin
        hit_d = 1'b1;
        sel_d = SIW'(i);
        off_d = gaddr - SLAVE_BASE[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign gnt_oh      = NUM_MASTERS'(1) << gnt_q;
  assign sel_ack     = s_ack_i[sel_q];
  assign sel_rdata   = s_rdata_i[int'(sel_q)*DATA_W +: DATA_W];
  assign cnt_d       = cnt_q + CNT_W'(1);
  assign timeout_hit = (cnt_d == CNT_W'(TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ptr_q   <= MIW'(NUM_MASTERS - 1);
      gnt_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      s_req_q <= '0;
      m_ack_q <= '0;
      m_err_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|arb_gnt) begin
            gnt_q   <= arb_idx;
            ptr_q   <= arb_idx;
            we_q    <= m_we_i[arb_idx];
            addr_q  <= off_d;
            wdata_q <= m_wdata_i[int'(arb_idx)*DATA_W +: DATA_W];
            be_q    <= m_be_i[int'(arb_idx)*BE_W +: BE_W];
            sel_q   <= sel_d;
            cnt_q   <= '0;
            if (hit_d) begin
              s_req_q <= NUM_SLAVES'(1) << sel_d;
              state_q <= ST_ACTIVE;
            end else begin
              state_q <= ST_ERR;
            end
          end
        end
        ST_ACTIVE: begin
          cnt_q <= cnt_d;
          // A real ack wins over a timeout landing in the same cycle.
          if (sel_ack) begin
            s_req_q <= '0;
            m_ack_q <= gnt_oh;
            m_err_q <= '0;
            rdata_q <= we_q ? '0 : sel_rdata;
            state_q <= ST_RESP;
          end else if (timeout_hit) begin
            s_req_q <= '0;
            m_ack_q <= gnt_oh;
            m_err_q <= gnt_oh;
            rdata_q <= '0;
            state_q <= ST_RESP;
          end
        end
        ST_ERR: begin
          m_ack_q <= gnt_oh;
          m_err_q <= gnt_oh;
          rdata_q <= '0;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          m_ack_q <= '0;
          m_err_q <= '0;
          rdata_q <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_ack_o   = m_ack_q;
  assign m_err_o   = m_err_q;
  assign m_rdata_o = rdata_q;
  assign s_req_o   = s_req_q;
  assign s_we_o    = we_q;
  assign s_addr_o  = addr_q;
  assign s_wdata_o = wdata_q;
  assign s_be_o    = be_q;

endmodule

// File: tb/tb_bus_arb_intercon.sv
module tb_bus_arb_intercon;

  localparam int TMO = 4;

  logic        clk, rst_n;
  logic [1:0]  m_req, m_we, m_ack, m_err;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_be;
  logic [31:0] m_rdata;
  logic [2:0]  s_req, s_ack;
  logic        s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic [95:0] s_rdata;

  // slave0 0x1000..0x13FF, slave1 0x2000..0x2FFF, slave2 0x2800..0x37FF (overlaps slave1)
  bus_arb_intercon #(
    .NUM_MASTERS (2),
    .NUM_SLAVES  (3),
    .ADDR_W      (32),
    .DATA_W      (32),
    .SLAVE_BASE  ({32'h0000_2800, 32'h0000_2000, 32'h0000_1000}),
    .SLAVE_WORDS ({32'h0000_0400, 32'h0000_0400, 32'h0000_0100}),
    .TIMEOUT     (TMO)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .m_req_i   (m_req),
    .m_we_i    (m_we),
    .m_addr_i  (m_addr),
    .m_wdata_i (m_wdata),
    .m_be_i    (m_be),
    .m_ack_o   (m_ack),
    .m_err_o   (m_err),
    .m_rdata_o (m_rdata),
    .s_req_o   (s_req),
    .s_we_o    (s_we),
    .s_addr_o  (s_addr),
    .s_wdata_o (s_wdata),
    .s_be_o    (s_be),
    .s_ack_i   (s_ack),
    .s_rdata_i (s_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          dly;   // 0 = slave never acks
    logic [31:0] srd;
    bit          spur;  // a non-selected slave acks in the first ACTIVE cycle
    int          sel;   // -1 = decode miss
    logic [31:0] saddr;
  } vec_t;

  // Slave responder state
  int          resp_dly = 0;
  logic [31:0] resp_data = '0;
  bit          spur = 1'b0;
  int          scyc = 0;
  int          sreq_hi = 0;
  int          spur_j;
  logic [2:0]  obs_sreq;
  logic [31:0] obs_saddr, obs_swdata;
  logic        obs_swe;
  logic [3:0]  obs_sbe;

  initial begin
    s_ack   = '0;
    s_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      s_ack = '0;
      if (|s_req) begin
        scyc++;
        sreq_hi++;
        for (int i = 0; i < 3; i++) s_rdata[i*32 +: 32] = 32'h0BAD_0000 | 32'(i);
        if (scyc == 1) begin
          obs_sreq   = s_req;
          obs_saddr  = s_addr;
          obs_swe    = s_we;
          obs_sbe    = s_be;
          obs_swdata = s_wdata;
          if (spur) begin
            spur_j = s_req[0] ? 1 : 0;
            s_ack[spur_j] = 1'b1;
            s_rdata[spur_j*32 +: 32] = 32'hBADB_AD00;
          end
        end
        if (resp_dly > 0 && scyc == resp_dly) begin
          for (int i = 0; i < 3; i++) begin
            if (s_req[i]) begin
              s_ack[i] = 1'b1;
              s_rdata[i*32 +: 32] = resp_data;
            end
          end
        end
      end else begin
        scyc = 0;
      end
    end
  end

  // Scoreboard: every master-side completion is matched against the queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (|m_ack || |m_err)) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_ack", 64'({m_ack, m_err}), 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_m_ack", 64'(m_ack), 64'(e.ack));
          chk("sb_m_err", 64'(m_err), 64'(e.err));
          chk("sb_m_rdata", 64'(m_rdata), 64'(e.rdata));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   waited;
    bit   got;
    bit   err;
    int   exp_lat, exp_cyc;
    logic [2:0] exp_sreq;
    err      = (v.sel < 0) || (v.dly == 0);
    exp_sreq = (v.sel < 0) ? 3'b000 : 3'(1 << v.sel);
    exp_lat  = (v.sel < 0) ? 2 : ((v.dly == 0) ? TMO + 1 : v.dly + 1);
    exp_cyc  = (v.sel < 0) ? 0 : ((v.dly == 0) ? TMO : v.dly);
    resp_dly  = v.dly;
    resp_data = v.srd;
    spur      = v.spur;
    sreq_hi   = 0;
    obs_sreq  = '0;
    e.ack   = 2'(1 << v.m);
    e.err   = err ? 2'(1 << v.m) : 2'b00;
    e.rdata = (v.we || err) ? 32'h0 : v.srd;
    sb_q.push_back(e);
    m_we[v.m]             = v.we;
    m_addr[v.m*32 +: 32]  = v.addr;
    m_wdata[v.m*32 +: 32] = v.wdata;
    m_be[v.m*4 +: 4]      = v.be;
    m_req[v.m]            = 1'b1;
    waited = 0;
    got    = 1'b0;
    while (!got && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
      got = m_ack[v.m];
    end
    m_req[v.m] = 1'b0;
    chk("ack_seen", 64'(got), 64'd1);
    chk("ack_latency", 64'(waited), 64'(exp_lat));
    @(posedge clk);
    #3;
    chk("s_req_onehot", 64'(obs_sreq), 64'(exp_sreq));
    chk("s_req_cycles", 64'(sreq_hi), 64'(exp_cyc));
    if (v.sel >= 0) begin
      chk("s_addr", 64'(obs_saddr), 64'(v.saddr));
      chk("s_we", 64'(obs_swe), 64'(v.we));
      if (v.we) begin
        chk("s_be", 64'(obs_sbe), 64'(v.be));
        chk("s_wdata", 64'(obs_swdata), 64'(v.wdata));
      end
    end
    spur = 1'b0;
  endtask

  vec_t vt[12];

  initial begin
    int   waited;
    logic [1:0] who;
    exp_t e;

    vt[0]  = '{0, 1'b0, 32'h0000_1004, 32'h0,         4'hF,    2, 32'hDEAD_BEEF, 1'b0,  0, 32'h004};
    vt[1]  = '{1, 1'b0, 32'h0000_2010, 32'h0,         4'hF,    1, 32'hCAFE_F00D, 1'b0,  1, 32'h010};
    vt[2]  = '{0, 1'b1, 32'h0000_3008, 32'h1234_5678, 4'b0011, 3, 32'h55AA_55AA, 1'b0,  2, 32'h808};
    vt[3]  = '{1, 1'b1, 32'hFFFF_0000, 32'h1111_2222, 4'hF,    1, 32'h0,         1'b0, -1, 32'h0};
    vt[4]  = '{0, 1'b0, 32'h0000_13FC, 32'h0,         4'hF,    1, 32'h13FC_13FC, 1'b0,  0, 32'h3FC};
    vt[5]  = '{0, 1'b0, 32'h0000_1400, 32'h0,         4'hF,    1, 32'h0,         1'b0, -1, 32'h0};
    vt[6]  = '{1, 1'b0, 32'h0000_0FFC, 32'h0,         4'hF,    1, 32'h0,         1'b0, -1, 32'h0};
    vt[7]  = '{1, 1'b0, 32'h0000_2804, 32'h0,         4'hF,    2, 32'h2804_0001, 1'b0,  1, 32'h804};
    vt[8]  = '{0, 1'b0, 32'h0000_2000, 32'h0,         4'hF,    0, 32'h0,         1'b0,  1, 32'h000};
    vt[9]  = '{1, 1'b0, 32'h0000_2004, 32'h0,         4'hF,    1, 32'h600D_D00D, 1'b0,  1, 32'h004};
    vt[10] = '{0, 1'b0, 32'h0000_1008, 32'h0,         4'hF,    3, 32'h5EA1_5EA1, 1'b1,  0, 32'h008};
    vt[11] = '{1, 1'b1, 32'h0000_37FC, 32'hA5A5_A5A5, 4'b1100, 1, 32'h0,         1'b0,  2, 32'hFFC};

    rst_n = 1'b0;
    m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_be = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_req", 64'(s_req), 64'd0);
    chk("rst_m_ack", 64'(m_ack), 64'd0);
    chk("rst_m_err", 64'(m_err), 64'd0);
    chk("rst_m_rdata", 64'(m_rdata), 64'd0);
    chk("rst_s_bcast", 64'({s_we, s_be, s_addr}), 64'd0);
    chk("rst_s_wdata", 64'(s_wdata), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) run_vec(vt[i]);

    // Reset while a transaction is in ACTIVE: no response may follow
    resp_dly = 0;
    m_we[0] = 1'b0;
    m_addr[31:0] = 32'h0000_1000;
    m_req[0] = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("mid_s_req_before_rst", 64'(s_req), 64'b001);
    rst_n = 1'b0;
    #1;
    chk("mid_s_req_async", 64'(s_req), 64'd0);
    chk("mid_m_ack_async", 64'(m_ack), 64'd0);
    m_req = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_outputs", 64'({m_ack, m_err, s_req}), 64'd0);
    rst_n = 1'b1;

    // Contention from reset: strict alternation starting with master 0
    resp_dly  = 1;
    resp_data = 32'h7777_0000;
    m_we = 2'b00;
    m_addr = {32'h0000_2000, 32'h0000_1000};
    for (int t = 0; t < 4; t++) begin
      e.ack   = (t % 2 == 0) ? 2'b01 : 2'b10;
      e.err   = 2'b00;
      e.rdata = 32'h7777_0000;
      sb_q.push_back(e);
    end
    m_req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      waited = 0;
      who    = '0;
      while (who == 2'b00 && waited < 20) begin
        @(posedge clk);
        #1;
        waited++;
        who = m_ack;
      end
      chk("rr_ack_seen", 64'(who != 2'b00), 64'd1);
      m_req = m_req & ~who;
      @(posedge clk);
      #1;
      if (t < 3) m_req = 2'b11;
    end
    m_req = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
